// File: rtl/scene_compositor_if.sv
// Draw-list bus between the scene source (master) and the compositor (slave).
// Carries the per-frame content inputs and the registered draw list.
interface scene_compositor_if #(
  parameter int N_OBJ  = 6,
  parameter int ID_W   = 5,
  parameter int POS_W  = 17,
  parameter int XOFF_W = 9
) ();
  logic                        frame_tick;
  logic [1:0]                  screen_req;
  logic [N_OBJ*ID_W-1:0]       menu_ids;
  logic [N_OBJ*POS_W-1:0]      menu_pos;
  logic [(N_OBJ-1)*ID_W-1:0]   lane_ids;
  logic [XOFF_W-1:0]           xoffset;
  logic [N_OBJ*ID_W-1:0]       obj_ids;
  logic [N_OBJ*POS_W-1:0]      obj_pos;
  logic [1:0]                  cur_screen;
  logic                        blanking;
  logic [7:0]                  frames_on_screen;

  modport master (
    output frame_tick, screen_req, menu_ids, menu_pos, lane_ids, xoffset,
    input  obj_ids, obj_pos, cur_screen, blanking, frames_on_screen
  );

  modport slave (
    input  frame_tick, screen_req, menu_ids, menu_pos, lane_ids, xoffset,
    output obj_ids, obj_pos, cur_screen, blanking, frames_on_screen
  );
endinterface

// File: rtl/scene_compositor.sv
// Frame-synchronous screen compositor: builds the per-object draw list for the
// current screen and inserts blank frames on every screen change.
//
// state | meaning
// SHOW  | draw list tracks cur_screen content, reloaded every frame tick
// BLANK | draw list forced empty while counting down to the target screen
module scene_compositor #(
  parameter int N_OBJ        = 6,
  parameter int ID_W         = 5,
  parameter int POS_W        = 17,
  parameter int XOFF_W       = 9,
  parameter int LANE_BASE    = 64,
  parameter int LANE_STEP    = 48,
  parameter int MAIN_ID      = 12,
  parameter int CURSOR_ID    = 4,
  parameter int BLANK_FRAMES = 2
) (
  input logic               CLOCK_50,
  input logic               reset_b,
  scene_compositor_if.slave bus
);

  localparam int RAW_W = $clog2(LANE_BASE + (N_OBJ - 2) * LANE_STEP + (1 << XOFF_W));
  localparam int SUM_W = (RAW_W > POS_W) ? RAW_W : POS_W;
  localparam int CNT_W = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES + 1) : 1;

  typedef enum logic {SHOW, BLANK} state_t;

  state_t                 state, state_nx;
  logic [CNT_W-1:0]       cnt, cnt_nx;
  logic [1:0]             target, target_nx;
  logic [1:0]             cur, cur_nx;
  logic                   blank_r, blank_nx;
  logic [7:0]             frames, frames_nx;
  logic [N_OBJ*ID_W-1:0]  ids, ids_nx;
  logic [N_OBJ*POS_W-1:0] pos, pos_nx;
  logic                   load;
  logic [1:0]             load_scr;
  logic [SUM_W-1:0]       lane_sum;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_b) begin
      state   <= SHOW;
      cnt     <= '0;
      target  <= 2'b00;
      cur     <= 2'b00;
      blank_r <= 1'b0;
      frames  <= 8'd0;
      ids     <= {N_OBJ{ID_W'(MAIN_ID)}};
      pos     <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      target  <= target_nx;
      cur     <= cur_nx;
      blank_r <= blank_nx;
      frames  <= frames_nx;
      ids     <= ids_nx;
      pos     <= pos_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    target_nx = target;
    cur_nx    = cur;
    blank_nx  = blank_r;
    frames_nx = frames;
    ids_nx    = ids;
    pos_nx    = pos;
    load      = 1'b0;
    load_scr  = cur;
    lane_sum  = '0;

    if (bus.frame_tick) begin
      case (state)
        SHOW: begin
          if (bus.screen_req == cur || bus.screen_req == 2'b11) begin
            load      = 1'b1;
            frames_nx = (frames == 8'd255) ? frames : frames + 8'd1;
          end else if (BLANK_FRAMES > 0) begin
            target_nx = bus.screen_req;
            cnt_nx    = CNT_W'(BLANK_FRAMES);
            state_nx  = BLANK;
            blank_nx  = 1'b1;
            ids_nx    = '0;
            pos_nx    = '0;
          end else begin
            cur_nx    = bus.screen_req;
            load_scr  = bus.screen_req;
            load      = 1'b1;
            frames_nx = 8'd0;
          end
        end
        BLANK: begin
          cnt_nx = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            cur_nx    = target;
            load_scr  = target;
            load      = 1'b1;
            blank_nx  = 1'b0;
            frames_nx = 8'd0;
            state_nx  = SHOW;
          end
        end
      endcase
    end

    // cur/target never hold 11, so the default arm only ever sees main
    if (load) begin
      case (load_scr)
        2'b01: begin
          ids_nx = bus.menu_ids;
          pos_nx = bus.menu_pos;
        end
        2'b10: begin
          ids_nx[0 +: ID_W]  = ID_W'(CURSOR_ID);
          pos_nx[0 +: POS_W] = '0;
          for (int k = 1; k < N_OBJ; k++) begin
            lane_sum = SUM_W'(LANE_BASE + (k - 1) * LANE_STEP) + SUM_W'(bus.xoffset);
            ids_nx[k*ID_W +: ID_W]   = bus.lane_ids[(k-1)*ID_W +: ID_W];
            pos_nx[k*POS_W +: POS_W] = lane_sum[POS_W-1:0];
          end
        end
        default: begin
          ids_nx = {N_OBJ{ID_W'(MAIN_ID)}};
          pos_nx = '0;
        end
      endcase
    end
  end

  assign bus.obj_ids          = ids;
  assign bus.obj_pos          = pos;
  assign bus.cur_screen       = cur;
  assign bus.blanking         = blank_r;
  assign bus.frames_on_screen = frames;

endmodule

// File: tb/tb_scene_compositor.sv
// Bench for scene_compositor: one instance with two blank frames, one with none,
// both driven identically and compared against a frame-level reference model.
module tb_scene_compositor;
  localparam int N_OBJ     = 6;
  localparam int ID_W      = 5;
  localparam int POS_W     = 17;
  localparam int XOFF_W    = 9;
  localparam int LANE_BASE = 64;
  localparam int LANE_STEP = 48;
  localparam int MAIN_ID   = 12;
  localparam int CURSOR_ID = 4;

  logic CLOCK_50 = 1'b0;
  logic reset_b  = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  scene_compositor_if #(.N_OBJ(N_OBJ), .ID_W(ID_W), .POS_W(POS_W), .XOFF_W(XOFF_W)) if_a ();
  scene_compositor_if #(.N_OBJ(N_OBJ), .ID_W(ID_W), .POS_W(POS_W), .XOFF_W(XOFF_W)) if_z ();

  scene_compositor #(
    .N_OBJ(N_OBJ), .ID_W(ID_W), .POS_W(POS_W), .XOFF_W(XOFF_W),
    .LANE_BASE(LANE_BASE), .LANE_STEP(LANE_STEP), .MAIN_ID(MAIN_ID),
    .CURSOR_ID(CURSOR_ID), .BLANK_FRAMES(2)
  ) dut_a (.CLOCK_50(CLOCK_50), .reset_b(reset_b), .bus(if_a.slave));

  scene_compositor #(
    .N_OBJ(N_OBJ), .ID_W(ID_W), .POS_W(POS_W), .XOFF_W(XOFF_W),
    .LANE_BASE(LANE_BASE), .LANE_STEP(LANE_STEP), .MAIN_ID(MAIN_ID),
    .CURSOR_ID(CURSOR_ID), .BLANK_FRAMES(0)
  ) dut_z (.CLOCK_50(CLOCK_50), .reset_b(reset_b), .bus(if_z.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus, as plain per-object values
  int req;
  int tick;
  int xoff;
  int m_id  [N_OBJ];
  int m_pos [N_OBJ];
  int l_id  [N_OBJ-1];

  // reference model, one slot per instance
  int bf        [2] = '{2, 0};
  int cur       [2];
  int target    [2];
  int blank_left[2];
  int frames    [2];
  int e_id      [2][N_OBJ];
  int e_pos     [2][N_OBJ];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    logic [N_OBJ*ID_W-1:0]     mi;
    logic [N_OBJ*POS_W-1:0]    mp;
    logic [(N_OBJ-1)*ID_W-1:0] li;
    for (int k = 0; k < N_OBJ; k++) begin
      mi[k*ID_W +: ID_W]   = ID_W'(m_id[k]);
      mp[k*POS_W +: POS_W] = POS_W'(m_pos[k]);
    end
    for (int k = 0; k < N_OBJ-1; k++) li[k*ID_W +: ID_W] = ID_W'(l_id[k]);
    if_a.frame_tick = tick[0];   if_z.frame_tick = tick[0];
    if_a.screen_req = 2'(req);   if_z.screen_req = 2'(req);
    if_a.menu_ids   = mi;        if_z.menu_ids   = mi;
    if_a.menu_pos   = mp;        if_z.menu_pos   = mp;
    if_a.lane_ids   = li;        if_z.lane_ids   = li;
    if_a.xoffset    = XOFF_W'(xoff); if_z.xoffset = XOFF_W'(xoff);
  endtask

  task automatic model_show(input int d, input int s);
    for (int k = 0; k < N_OBJ; k++) begin
      if (s == 1) begin
        e_id[d][k] = m_id[k];  e_pos[d][k] = m_pos[k];
      end else if (s == 2) begin
        e_id[d][k]  = (k == 0) ? CURSOR_ID : l_id[k-1];
        e_pos[d][k] = (k == 0) ? 0 : (LANE_BASE + (k-1)*LANE_STEP + xoff) % (1 << POS_W);
      end else begin
        e_id[d][k] = MAIN_ID;  e_pos[d][k] = 0;
      end
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      cur[d] = 0; target[d] = 0; blank_left[d] = 0; frames[d] = 0;
      model_show(d, 0);
    end
  endtask

  task automatic model_tick();
    for (int d = 0; d < 2; d++) begin
      if (blank_left[d] > 0) begin
        blank_left[d]--;
        if (blank_left[d] == 0) begin
          cur[d] = target[d]; frames[d] = 0; model_show(d, cur[d]);
        end
      end else if (req == cur[d] || req == 3) begin
        model_show(d, cur[d]);
        frames[d] = (frames[d] >= 255) ? 255 : frames[d] + 1;
      end else if (bf[d] > 0) begin
        target[d] = req; blank_left[d] = bf[d];
        for (int k = 0; k < N_OBJ; k++) begin e_id[d][k] = 0; e_pos[d][k] = 0; end
      end else begin
        cur[d] = req; frames[d] = 0; model_show(d, req);
      end
    end
  endtask

  task automatic check_dut(input int d, input logic [N_OBJ*ID_W-1:0] ids,
                           input logic [N_OBJ*POS_W-1:0] pos, input logic [1:0] cs,
                           input logic bl, input logic [7:0] fr);
    string p;
    p = (d == 0) ? "bf2" : "bf0";
    check({p, ".cur_screen"}, int'(cs), cur[d]);
    check({p, ".blanking"}, int'(bl), (blank_left[d] > 0) ? 1 : 0);
    check({p, ".frames_on_screen"}, int'(fr), frames[d]);
    for (int k = 0; k < N_OBJ; k++) begin
      check($sformatf("%s.id[%0d]", p, k), int'(ids[k*ID_W +: ID_W]), e_id[d][k]);
      check($sformatf("%s.pos[%0d]", p, k), int'(pos[k*POS_W +: POS_W]), e_pos[d][k]);
    end
  endtask

  // one clock cycle: inputs applied at negedge, outputs checked at the next negedge
  task automatic step(input int t);
    tick = t;
    drive_inputs();
    @(posedge CLOCK_50);
    if (!reset_b) model_reset();
    else if (tick != 0) model_tick();
    @(negedge CLOCK_50);
    tick = 0;
    drive_inputs();
    check_dut(0, if_a.obj_ids, if_a.obj_pos, if_a.cur_screen, if_a.blanking, if_a.frames_on_screen);
    check_dut(1, if_z.obj_ids, if_z.obj_pos, if_z.cur_screen, if_z.blanking, if_z.frames_on_screen);
  endtask

  initial begin
    req = 0; tick = 0; xoff = 0;
    for (int k = 0; k < N_OBJ; k++) begin m_id[k] = 0; m_pos[k] = 0; end
    for (int k = 0; k < N_OBJ-1; k++) l_id[k] = 0;
    model_reset();
    drive_inputs();
    @(negedge CLOCK_50);

    reset_b = 1'b0;
    step(1);
    step(0);
    reset_b = 1'b1;

    // main screen, interleaved idle cycles
    for (int i = 0; i < 3; i++) begin step(1); step(0); end
    check("main.frames_after_3", frames[0], 3);

    // main -> game with scroll 5
    req = 2; xoff = 5;
    for (int k = 0; k < N_OBJ-1; k++) l_id[k] = k + 1;
    for (int i = 0; i < 3; i++) begin step(1); step(0); end
    check("game.lane5_pos", e_pos[0][5], 261);

    // maximum scroll, then change it without a tick
    xoff = 511;
    step(1);
    xoff = 100;
    step(0); step(0);
    step(1);

    // invalid request held: frame counter saturates
    req = 3;
    for (int i = 0; i < 300; i++) step(1);

    // start game -> menu, reset together with a tick mid-blank
    req = 1;
    for (int k = 0; k < N_OBJ; k++) begin m_id[k] = 7; m_pos[k] = k * 100; end
    step(1);
    reset_b = 1'b0;
    step(1);
    reset_b = 1'b1;
    step(0);

    // main -> menu
    for (int i = 0; i < 4; i++) step(1);

    // randomized phase
    for (int i = 0; i < 600; i++) begin
      req  = $urandom_range(0, 3);
      xoff = $urandom_range(0, 511);
      for (int k = 0; k < N_OBJ; k++) begin
        m_id[k]  = $urandom_range(0, 31);
        m_pos[k] = $urandom_range(0, (1 << POS_W) - 1);
      end
      for (int k = 0; k < N_OBJ-1; k++) l_id[k] = $urandom_range(0, 31);
      reset_b = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
      step(($urandom_range(0, 2) != 0) ? 1 : 0);
    end
    reset_b = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/scene_compositor.md
Name: scene_compositor

Overview:
- Registered, parametrised successor to the top-level screen mux; owns the per-object draw list (sprite IDs and positions) handed to Graphics.
- Selects content per screen (main, menu, game) for N_OBJ objects and computes game lane positions from parameters.
- Updates outputs only on frame boundaries, so changes are tear-free.
- Inserts a configurable number of blank frames on every screen change.

Parameters:
N_OBJ, 6, number of drawable objects (object 0 = cursor/hit marker in game)
ID_W, 5, sprite ID width per object; ID 0 = draw nothing
POS_W, 17, position field width per object
XOFF_W, 9, width of scroll offset input
LANE_BASE, 64, position of lane object 1 at xoffset 0
LANE_STEP, 48, position spacing between consecutive lane objects
MAIN_ID, 12, sprite ID drawn by every object on the main screen
CURSOR_ID, 4, sprite ID of object 0 on the game screen
BLANK_FRAMES, 2, frame ticks spent blank during a screen change (0 allowed)

Ports:
CLOCK_50  in  1  system clock; single clock domain
reset_b  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle pulse per video frame
screen_req  in  2  requested screen: 00 main, 01 menu, 10 game, 11 invalid
menu_ids  in  N_OBJ*ID_W  menu sprite IDs; object k in slice [k*ID_W +: ID_W]
menu_pos  in  N_OBJ*POS_W  menu positions; object k in slice [k*POS_W +: POS_W]
lane_ids  in  (N_OBJ-1)*ID_W  game lane sprite IDs for objects 1..N_OBJ-1
xoffset  in  XOFF_W  game scroll offset
obj_ids  out  N_OBJ*ID_W  registered draw list IDs
obj_pos  out  N_OBJ*POS_W  registered draw list positions
cur_screen  out  2  screen currently displayed
blanking  out  1  high while in BLANK state
frames_on_screen  out  8  frame ticks since the last screen entry; saturates at 255

Behaviour:
- All state updates on the CLOCK_50 rising edge.
- reset_b=0 overrides everything, including a simultaneous frame_tick. On reset:
  - state=SHOW, cur_screen=00, blanking=0, frames_on_screen=0.
  - obj_ids = MAIN_ID in every slot; obj_pos = 0.
- Outside reset, registers change only in cycles where frame_tick=1. Inputs are sampled in the tick cycle; the result is visible from the next cycle and held until the next tick.
- Content function for screen S, evaluated on sampled inputs:
  - 00 main: all IDs = MAIN_ID; all positions = 0.
  - 01 menu: obj_ids = menu_ids; obj_pos = menu_pos, passed through unmodified.
  - 10 game:
    - Object 0: ID = CURSOR_ID, position = 0.
    - Object k (1..N_OBJ-1): ID = lane_ids slice k-1.
    - Object k position = LANE_BASE + (k-1)*LANE_STEP + xoffset, with xoffset zero-extended and the sum truncated modulo 2^POS_W.
- State SHOW, on a tick:
  - Case 1: screen_req == cur_screen, or screen_req == 11:
    - Reload content for cur_screen, so game and menu track live inputs every frame.
    - frames_on_screen += 1, saturating at 255.
  - Case 2: screen_req is a different valid screen and BLANK_FRAMES > 0:
    - Latch target = screen_req; cnt = BLANK_FRAMES.
    - State -> BLANK; blanking = 1.
    - obj_ids all 0; obj_pos all 0.
    - cur_screen unchanged.
  - Case 3: screen_req is a different valid screen and BLANK_FRAMES == 0:
    - cur_screen = screen_req; load its content; frames_on_screen = 0.
    - No BLANK state is entered.
- State BLANK, on a tick:
  - cnt -= 1. Outputs stay zero and screen_req is ignored; target stays as latched.
  - When cnt reaches 0 on this tick:
    - cur_screen = target; load its content from the inputs sampled this tick.
    - blanking = 0; frames_on_screen = 0; state -> SHOW.
  - Result: exactly BLANK_FRAMES frames show a blank draw list.
- In BLANK, a changed screen_req is evaluated only after returning to SHOW, on the next tick.
- Reset during BLANK returns to main SHOW immediately; the latched target is discarded.
- The position arithmetic width is sized to hold LANE_BASE + (N_OBJ-2)*LANE_STEP + 2^XOFF_W - 1 before truncation to POS_W. No sign handling.

Test Plan:
- Reset, then 3 ticks with screen_req=00:
  - obj_ids all 12, obj_pos all 0, cur_screen=00, blanking=0.
  - frames_on_screen = 3.
- From main, set screen_req=10, xoffset=5, lane_ids = 1,2,3,4,5, then apply ticks:
  - Ticks 1 and 2: blanking=1, all outputs 0.
  - After tick 3 (cnt reaches 0): cur_screen=10, IDs 4,1,2,3,4,5, positions 0,69,117,165,213,261, frames_on_screen=0.
- In game, set xoffset=511 and tick:
  - Positions 0,575,623,671,719,767.
  - Change xoffset between ticks: outputs unchanged until the next tick.
- Hold screen_req=11 in game for 300 ticks:
  - No screen change.
  - frames_on_screen saturates at 255.
- Start a transition to menu; after the first BLANK tick, assert reset_b=0 together with a frame_tick:
  - Next cycle shows main reset state: blanking=0, cur_screen=00.
- With BLANK_FRAMES=0, request menu with menu_ids = 7 in each slot and menu_pos = k*100:
  - After one tick: menu content loaded directly, blanking never asserted.
